dma_irq_coalescer: RTL and testbench
====================================

# dma_irq_coalescer

Interrupt-request generator placed directly upstream of the DMA write IRQ synchroniser/latency block. It counts completed AXI write bursts from the DMA write engine and raises a level request `irq_req` (which drives the downstream block's `D` input) once a programmable burst threshold is reached, or once an optional timeout expires with at least one burst pending. `irq_req` is held until the software acknowledge (`IRQ_STATUS[1]`), so the downstream block cannot miss a request.

## Interface
- `COUNT_W`, 16: width of burst counters and threshold.
- `TIMER_W`, 32: width of the timeout counter and timeout register.
- `M_AXI_ACLK`  in  1  clock for all logic.
- `M_AXI_ARESET`  in  1  asynchronous, active-high reset.
- `enable`  in  1  coalescer enable (`IRQ_STATUS[0]`).
- `ack`  in  1  software acknowledge (`IRQ_STATUS[1]`), level.
- `burst_done`  in  1  one-cycle pulse per completed write response (`BVALID & BREADY`).
- `burst_err`  in  1  qualifies `burst_done`: BRESP not OKAY.
- `threshold`  in  COUNT_W  bursts per interrupt; 0 treated as 1.
- `timeout`  in  TIMER_W  cycles from first pending burst to forced request; 0 disables.
- `irq_req`  out  1  request level to the downstream IRQ block.
- `irq_count`  out  COUNT_W  bursts covered by the current/last request.
- `irq_err`  out  1  at least one errored burst within `irq_count`.
- `pending`  out  COUNT_W  bursts counted since the last snapshot.
- `overflow`  out  1  sticky; `pending` saturated at all-ones.

## Operation
- States: IDLE, ACCUM, REQ.
- Reset: state IDLE; all outputs 0; timer 0.
- IDLE: `pending`=0, timer=0. `enable=1` and `burst_done` -> ACCUM with `pending`=1.
- ACCUM: each `burst_done` increments `pending`, saturating at 2^COUNT_W-1 and setting `overflow`. `burst_err` sets an internal error flag. Timer increments every cycle.
- Request trigger in ACCUM: the next-value of `pending` >= effective threshold, or (timeout != 0 and timer == timeout-1). On trigger -> REQ: `irq_count` <= next `pending`, `irq_err` <= next error flag, `pending` <= 0, error flag <= 0, timer <= 0.
- REQ: `irq_req`=1. Bursts keep incrementing `pending`/error flag; no new trigger. `ack`=1 -> `irq_req` cleared; next state ACCUM if `pending` (including a same-cycle burst) != 0, else IDLE; `overflow` cleared.
- `ack` in IDLE/ACCUM is ignored.
- `enable`=0 in any state: next cycle IDLE, `irq_req`=0, `pending`/timer/error/`overflow` cleared; `irq_count`/`irq_err` hold.
- A burst in the trigger cycle is included in the snapshot.
- Threshold changes take effect on the next comparison. Lowering the threshold below `pending` triggers on the next cycle.

## Timing
- All outputs are registered.
- Trigger in cycle N -> `irq_req`, `irq_count` valid at N+1.
- `ack` sampled high in cycle N (REQ) -> `irq_req` low at N+1.
- Minimum `irq_req` low gap between requests: 1 cycle.
- Timeout latency: `irq_req` rises exactly `timeout` cycles after the burst that entered ACCUM.
- Downstream adds its own 1-2 cycles. End-to-end request latency is measured there.

## Configuration
- `DMA_IRQ_TIMEOUT_EN` defined: timer, `timeout` port and timeout trigger present as above.
- Not defined: the `timeout` port is still present but ignored, and there is no timer logic. Only the threshold triggers, and `pending` below threshold waits indefinitely.

## Structure
- `dma_irq_pkg` holds the state enum (IDLE/ACCUM/REQ), `COUNT_W`/`TIMER_W` defaults and the saturating-increment function.
- Sub-module `dma_irq_timer` contains the clear/run/expire counter and is instantiated only under `DMA_IRQ_TIMEOUT_EN`.

## Test plan
- Reset assertion mid-REQ -> asynchronous: `irq_req`=0, `irq_count`=0, `overflow`=0 immediately.
- Threshold test: threshold=4, four `burst_done` pulses 2 cycles apart -> `irq_req` high 1 cycle after the 4th pulse, `irq_count`=4. `ack` -> `irq_req` low next cycle, state IDLE.
- Timeout test: threshold=100, timeout=50, one burst -> `irq_req` rises 50 cycles later, `irq_count`=1. With the macro undefined, no request occurs within 1000 cycles.
- Carry-over test: threshold=2, bursts during REQ (3 of them, one with `burst_err`), then `ack` -> REQ re-entered at the next cycle edge, `irq_count`=3, `irq_err`=1.
- Enable drop: `enable`=0 during ACCUM with `pending`=7 -> IDLE next cycle, `pending`=0. Bursts while disabled are ignored.
- Saturation test: COUNT_W=4, threshold=0xF via override, and 20 bursts during REQ -> `pending`=15, `overflow`=1. `ack` clears `overflow`.

Source files
------------

// File: rtl/dma_irq_pkg.sv
// rtl/dma_irq_pkg.sv - shared state encodings, default widths and saturating increment for dma_irq_coalescer
package dma_irq_pkg;

    localparam int COUNT_W_DEF = 16;
    localparam int TIMER_W_DEF = 32;

    // IDLE / ACCUM / REQ state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_REQ   = 2'd2;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/dma_irq_coalescer_if.sv
// rtl/dma_irq_coalescer_if.sv - control/status bundle between software-side driver and dma_irq_coalescer
interface dma_irq_coalescer_if #(
    parameter int COUNT_W = dma_irq_pkg::COUNT_W_DEF,
    parameter int TIMER_W = dma_irq_pkg::TIMER_W_DEF
);
    logic               enable;
    logic               ack;
    logic               burst_done;
    logic               burst_err;
    logic [COUNT_W-1:0] threshold;
    logic [TIMER_W-1:0] timeout;
    logic               irq_req;
    logic [COUNT_W-1:0] irq_count;
    logic               irq_err;
    logic [COUNT_W-1:0] pending;
    logic               overflow;

    modport master (
        output enable, ack, burst_done, burst_err, threshold, timeout,
        input  irq_req, irq_count, irq_err, pending, overflow
    );

    modport slave (
        input  enable, ack, burst_done, burst_err, threshold, timeout,
        output irq_req, irq_count, irq_err, pending, overflow
    );
endinterface

// File: rtl/dma_irq_timer.sv
// rtl/dma_irq_timer.sv - clear/run/expire cycle counter used for the coalescing timeout
module dma_irq_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               run,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);
    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (run)
            count <= count + TIMER_W'(1);
    end

    // Fires on the last counted cycle so the request lands exactly limit cycles after entry
    assign expire = run && (limit != '0) && (count == limit - TIMER_W'(1));

endmodule

// File: rtl/dma_irq_coalescer.sv
// rtl/dma_irq_coalescer.sv - write-burst interrupt coalescer; timeout trigger built only with DMA_IRQ_TIMEOUT_EN
module dma_irq_coalescer
    import dma_irq_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int TIMER_W = TIMER_W_DEF
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESET,
    dma_irq_coalescer_if.slave  bus
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [1:0]         state;
    logic [COUNT_W-1:0] pending_q;
    logic [COUNT_W-1:0] irq_count_q;
    logic               irq_req_q;
    logic               irq_err_q;
    logic               overflow_q;
    logic               err_q;

    logic [COUNT_W-1:0] pending_nxt;
    logic [COUNT_W-1:0] thr_eff;
    logic               err_nxt;
    logic               sat_hit;
    logic               trigger;
    logic               timer_expire;

    always_comb begin
        pending_nxt = bus.burst_done ? COUNT_W'(sat_inc(32'(pending_q), 32'(CNT_MAX))) : pending_q;
        sat_hit     = bus.burst_done && (pending_q == CNT_MAX);
        err_nxt     = err_q | (bus.burst_done & bus.burst_err);
        thr_eff     = (bus.threshold == '0) ? COUNT_W'(1) : bus.threshold;
        trigger     = (state == ST_ACCUM) && ((pending_nxt >= thr_eff) || timer_expire);
    end

`ifdef DMA_IRQ_TIMEOUT_EN
    // Timer only runs while accumulating; it restarts from zero on every entry to ACCUM
    dma_irq_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk    (M_AXI_ACLK),
        .rst    (M_AXI_ARESET),
        .clear  (!bus.enable || (state != ST_ACCUM) || trigger),
        .run    (state == ST_ACCUM),
        .limit  (bus.timeout),
        .expire (timer_expire)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |bus.timeout;
    assign timer_expire   = 1'b0;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state       <= ST_IDLE;
            pending_q   <= '0;
            irq_count_q <= '0;
            irq_req_q   <= 1'b0;
            irq_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (!bus.enable) begin
            state      <= ST_IDLE;
            pending_q  <= '0;
            irq_req_q  <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.burst_done) begin
                        state     <= ST_ACCUM;
                        pending_q <= COUNT_W'(1);
                        err_q     <= bus.burst_err;
                    end
                end
                ST_ACCUM: begin
                    overflow_q <= overflow_q | sat_hit;
                    if (trigger) begin
                        state       <= ST_REQ;
                        irq_req_q   <= 1'b1;
                        irq_count_q <= pending_nxt;
                        irq_err_q   <= err_nxt;
                        pending_q   <= '0;
                        err_q       <= 1'b0;
                    end else begin
                        pending_q <= pending_nxt;
                        err_q     <= err_nxt;
                    end
                end
                ST_REQ: begin
                    pending_q <= pending_nxt;
                    err_q     <= err_nxt;
                    if (bus.ack) begin
                        irq_req_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        state      <= (pending_nxt != '0) ? ST_ACCUM : ST_IDLE;
                    end else begin
                        overflow_q <= overflow_q | sat_hit;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.irq_req   = irq_req_q;
    assign bus.irq_count = irq_count_q;
    assign bus.irq_err   = irq_err_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_dma_irq_coalescer.sv
// tb/tb_dma_irq_coalescer.sv - directed table and sequence bench for dma_irq_coalescer
module tb_dma_irq_coalescer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dma_irq_coalescer_if #(.COUNT_W(16), .TIMER_W(32)) b1();
    dma_irq_coalescer_if #(.COUNT_W(4),  .TIMER_W(8))  b2();

    dma_irq_coalescer #(.COUNT_W(16), .TIMER_W(32)) dut1 (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (b1)
    );

    dma_irq_coalescer #(.COUNT_W(4), .TIMER_W(8)) dut2 (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (b2)
    );

    typedef struct {
        logic        en;
        logic        ack;
        logic        bd;
        logic        be;
        logic [15:0] thr;
        logic        req;
        logic [15:0] cnt;
        logic        err;
        logic [15:0] pend;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic add(input int en, input int ack, input int bd, input int be, input int thr,
                       input int req, input int cnt, input int err, input int pend, input int ovf);
        vec_t v;
        v.en = 1'(en); v.ack = 1'(ack); v.bd = 1'(bd); v.be = 1'(be); v.thr = 16'(thr);
        v.req = 1'(req); v.cnt = 16'(cnt); v.err = 1'(err); v.pend = 16'(pend); v.ovf = 1'(ovf);
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rise;

        b1.enable = 0; b1.ack = 0; b1.burst_done = 0; b1.burst_err = 0; b1.threshold = 0; b1.timeout = 0;
        b2.enable = 0; b2.ack = 0; b2.burst_done = 0; b2.burst_err = 0; b2.threshold = 0; b2.timeout = 0;

        // en ack bd be thr | req cnt err pend ovf
        add(1,0,1,0,4,   0,0,0,1,0);
        add(1,0,0,0,4,   0,0,0,1,0);
        add(1,0,1,0,4,   0,0,0,2,0);
        add(1,0,0,0,4,   0,0,0,2,0);
        add(1,0,1,1,4,   0,0,0,3,0);
        add(1,0,0,0,4,   0,0,0,3,0);
        add(1,0,1,0,4,   1,4,1,0,0);
        add(1,0,0,0,4,   1,4,1,0,0);
        add(1,1,0,0,4,   0,4,1,0,0);
        add(1,0,0,0,4,   0,4,1,0,0);
        add(1,1,0,0,4,   0,4,1,0,0);
        add(1,0,1,0,2,   0,4,1,1,0);
        add(1,0,1,0,2,   1,2,0,0,0);
        add(1,0,1,0,2,   1,2,0,1,0);
        add(1,0,1,1,2,   1,2,0,2,0);
        add(1,1,1,0,2,   0,2,0,3,0);
        add(1,0,0,0,2,   1,3,1,0,0);
        add(1,1,0,0,2,   0,3,1,0,0);
        add(1,0,1,0,0,   0,3,1,1,0);
        add(1,0,0,0,0,   1,1,0,0,0);
        add(1,1,0,0,0,   0,1,0,0,0);
        for (int k = 1; k <= 7; k++) add(1,0,1,0,100, 0,1,0,k,0);
        add(0,0,1,0,100, 0,1,0,0,0);
        add(0,0,1,1,100, 0,1,0,0,0);
        add(1,0,0,0,100, 0,1,0,0,0);
        add(1,0,1,0,100, 0,1,0,1,0);
        add(1,0,1,0,100, 0,1,0,2,0);
        add(1,0,1,0,100, 0,1,0,3,0);
        add(1,0,0,0,2,   1,3,0,0,0);
        add(0,0,0,0,2,   0,3,0,0,0);
        add(1,0,0,0,2,   0,3,0,0,0);

        tick();
        tick();
        check("reset_irq_req",   32'(b1.irq_req),   0);
        check("reset_irq_count", 32'(b1.irq_count), 0);
        check("reset_pending",   32'(b1.pending),   0);
        check("reset_overflow",  32'(b1.overflow),  0);
        check("reset_irq_err",   32'(b1.irq_err),   0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i]) begin
            @(negedge clk);
            b1.enable = vecs[i].en; b1.ack = vecs[i].ack; b1.burst_done = vecs[i].bd;
            b1.burst_err = vecs[i].be; b1.threshold = vecs[i].thr;
            tick();
            check($sformatf("v%0d_irq_req", i),   32'(b1.irq_req),   32'(vecs[i].req));
            check($sformatf("v%0d_irq_count", i), 32'(b1.irq_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_irq_err", i),   32'(b1.irq_err),   32'(vecs[i].err));
            check($sformatf("v%0d_pending", i),   32'(b1.pending),   32'(vecs[i].pend));
            check($sformatf("v%0d_overflow", i),  32'(b1.overflow),  32'(vecs[i].ovf));
        end

        // Timeout: one burst with threshold far away
        @(negedge clk);
        b1.enable = 1; b1.ack = 0; b1.threshold = 100; b1.timeout = 50; b1.burst_done = 1; b1.burst_err = 0;
        @(posedge clk);
        @(negedge clk);
        b1.burst_done = 0;
        rise = -1;
        for (int c = 1; c <= 1000; c++) begin
            if (c > 1) @(negedge clk);
            tick();
            if (b1.irq_req) begin
                rise = c;
                break;
            end
        end
`ifdef DMA_IRQ_TIMEOUT_EN
        check("timeout_rise_cycle", 32'(rise), 50);
        check("timeout_irq_count",  32'(b1.irq_count), 1);
        @(negedge clk);
        b1.ack = 1;
        tick();
        check("timeout_ack_irq_req", 32'(b1.irq_req), 0);
`else
        check("no_timeout_rise", 32'(rise), 32'(-1));
        check("no_timeout_pending", 32'(b1.pending), 1);
`endif
        @(negedge clk);
        b1.ack = 0; b1.timeout = 0; b1.enable = 0;
        tick();
        check("timeout_disable_pending", 32'(b1.pending), 0);

        // Park dut1 in REQ for the asynchronous reset check
        @(negedge clk);
        b1.enable = 1; b1.threshold = 1; b1.burst_done = 1;
        @(posedge clk);
        @(negedge clk);
        b1.burst_done = 0;
        tick();
        check("park_irq_req",   32'(b1.irq_req),   1);
        check("park_irq_count", 32'(b1.irq_count), 1);

        // Saturation on the narrow instance
        @(negedge clk);
        b2.enable = 1; b2.threshold = 4'hF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            b2.burst_done = 1;
            @(posedge clk);
        end
        #1;
        check("sat_first_req",   32'(b2.irq_req),   1);
        check("sat_first_count", 32'(b2.irq_count), 15);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            b2.burst_done = 1;
            @(posedge clk);
        end
        @(negedge clk);
        b2.burst_done = 0;
        tick();
        check("sat_pending",  32'(b2.pending),  15);
        check("sat_overflow", 32'(b2.overflow), 1);
        check("sat_req_held", 32'(b2.irq_req),  1);
        @(negedge clk);
        b2.ack = 1;
        tick();
        check("sat_ack_overflow", 32'(b2.overflow), 0);
        check("sat_ack_irq_req",  32'(b2.irq_req),  0);
        check("sat_ack_pending",  32'(b2.pending),  15);
        @(negedge clk);
        b2.ack = 0;
        tick();
        check("sat_retrigger_req",   32'(b2.irq_req),   1);
        check("sat_retrigger_count", 32'(b2.irq_count), 15);
        check("sat_retrigger_pend",  32'(b2.pending),   0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            b2.burst_done = 1;
            @(posedge clk);
        end
        @(negedge clk);
        b2.burst_done = 0;
        tick();
        check("sat2_overflow", 32'(b2.overflow), 1);
        check("sat2_pending",  32'(b2.pending),  15);

        // Asynchronous reset mid-REQ, away from any clock edge
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        check("areset_b1_irq_req",   32'(b1.irq_req),   0);
        check("areset_b1_irq_count", 32'(b1.irq_count), 0);
        check("areset_b2_irq_req",   32'(b2.irq_req),   0);
        check("areset_b2_irq_count", 32'(b2.irq_count), 0);
        check("areset_b2_overflow",  32'(b2.overflow),  0);
        check("areset_b2_pending",   32'(b2.pending),   0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
